// File: rtl/msrv32_dmem_slave_pkg.sv
// ----------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the data-memory responder:
//   - AHB htrans encodings and response codes
//   - 3-bit encodings for the dmem FSM states, plus the enum built on them
//   - merge_lanes(): combines new lane data with old data under a byte mask
// ----------------------------------------------------------------------------
package msrv32_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    localparam logic [2:0] DMEM_ST_IDLE = 3'd0;
    localparam logic [2:0] DMEM_ST_WAIT = 3'd1;
    localparam logic [2:0] DMEM_ST_DONE = 3'd2;
    localparam logic [2:0] DMEM_ST_ERR1 = 3'd3;
    localparam logic [2:0] DMEM_ST_ERR2 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = DMEM_ST_IDLE,
        ST_WAIT = DMEM_ST_WAIT,
        ST_DONE = DMEM_ST_DONE,
        ST_ERR1 = DMEM_ST_ERR1,
        ST_ERR2 = DMEM_ST_ERR2
    } dmem_state_t;

    // Lanes with mask bit set come from new_data, the rest from old_data.
    function automatic logic [31:0] merge_lanes(input logic [3:0]  mask,
                                                input logic [31:0] new_data,
                                                input logic [31:0] old_data);
        logic [31:0] merged;
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_data[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/msrv32_dmem_slave_if.sv
// ----------------------------------------------------------------------------
// msrv32_dmem_slave_if
// Core data-port bus between the load/store master and the data-memory slave.
//   ahb_htrans_in  [1:0]  transfer type (address phase)
//   d_addr_in      [31:0] byte address (address phase)
//   wr_req_in             1 write / 0 read (address phase)
//   wr_mask_in     [3:0]  byte-lane enables (data phase)
//   data_in        [31:0] write data (data phase)
//   ahb_ready_out         data phase completes / slave can accept
//   ahb_resp_out          0 OKAY, 1 ERROR
//   rdata_out      [31:0] read data
// ----------------------------------------------------------------------------
interface msrv32_dmem_slave_if;

    logic [1:0]  ahb_htrans_in;
    logic [31:0] d_addr_in;
    logic        wr_req_in;
    logic [3:0]  wr_mask_in;
    logic [31:0] data_in;
    logic        ahb_ready_out;
    logic        ahb_resp_out;
    logic [31:0] rdata_out;

    modport master (
        output ahb_htrans_in, d_addr_in, wr_req_in, wr_mask_in, data_in,
        input  ahb_ready_out, ahb_resp_out, rdata_out
    );

    modport slave (
        input  ahb_htrans_in, d_addr_in, wr_req_in, wr_mask_in, data_in,
        output ahb_ready_out, ahb_resp_out, rdata_out
    );

endinterface

// File: rtl/msrv32_dmem_array.sv
// ----------------------------------------------------------------------------
// msrv32_dmem_array
// Data RAM as four independent 8-bit lanes of DEPTH_WORDS entries.
//   clk    in  clock
//   we     in  [3:0]  per-lane write enable
//   waddr  in  [AW-1:0] write word index
//   wdata  in  [31:0] write data, lane i in bits [8i+7:8i]
//   re     in  read enable
//   raddr  in  [AW-1:0] read word index
//   rdata  out [31:0] registered read data (old contents on same-edge write)
// No reset: RAM contents survive core reset.
// ----------------------------------------------------------------------------
module msrv32_dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] lane_q;

        // Lane write port.
        always_ff @(posedge clk) begin
            if (we[g]) begin
                mem[waddr] <= wdata[8*g +: 8];
            end
        end

        // Lane synchronous read port; holds when not enabled.
        always_ff @(posedge clk) begin
            if (re) begin
                lane_q <= mem[raddr];
            end
        end

        assign rdata[8*g +: 8] = lane_q;
    end

endmodule

// File: rtl/msrv32_dmem_slave.sv
// ----------------------------------------------------------------------------
// msrv32_dmem_slave
// AHB-lite-style data-memory responder for the core's load/store port.
//   ms_riscv32_mp_clk_in  in  clock, rising edge
//   ms_riscv32_mp_rst_in  in  synchronous active-high reset
//   bus                   slave modport of msrv32_dmem_slave_if
// Address phases are accepted when htrans is NONSEQ/SEQ and ready is high.
// The following data phase completes in DONE (after WAIT_CYCLES wait states)
// or, for out-of-range addresses, via the two-cycle ERR1/ERR2 error response.
// ----------------------------------------------------------------------------
module msrv32_dmem_slave
    import msrv32_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                ms_riscv32_mp_clk_in,
    input  logic                ms_riscv32_mp_rst_in,
    msrv32_dmem_slave_if.slave  bus
);

    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [30:0] DEPTH_W   = 31'(DEPTH_WORDS);
    localparam bit          HAS_WAIT  = (WAIT_CYCLES != 0);

    logic clk;
    logic rst;
    assign clk = ms_riscv32_mp_clk_in;
    assign rst = ms_riscv32_mp_rst_in;

    dmem_state_t   state;
    dmem_state_t   state_next;
    logic [3:0]    wait_cnt;
    logic [3:0]    wait_cnt_next;
    logic          ready_r;
    logic          ready_next;
    logic          resp_r;
    logic          resp_next;
    logic [AW-1:0] idx_q;
    logic          wr_q;
    logic          rdata_zero;
    logic [3:0]    fwd_mask;
    logic [31:0]   fwd_data;

    // Word offset from the base; an address below the base wraps to a huge
    // value, so one unsigned compare covers both ends of the window.
    logic [30:0]   word_off;
    logic          addr_oor;
    logic [AW-1:0] acc_idx;
    logic          accept;
    logic          addr_lsb_unused;

    assign word_off        = {1'b0, bus.d_addr_in[31:2]} - {1'b0, BASE_ADDR[31:2]};
    assign addr_oor        = (word_off >= DEPTH_W);
    assign acc_idx         = word_off[AW-1:0];
    assign addr_lsb_unused = ^bus.d_addr_in[1:0];
    assign accept          = ((bus.ahb_htrans_in == HTRANS_NONSEQ) ||
                              (bus.ahb_htrans_in == HTRANS_SEQ)) && ready_r;

    // Next-state, wait counter and next registered ready/resp.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        ready_next    = 1'b1;
        resp_next     = RESP_OKAY;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (accept) begin
                    if (addr_oor) begin
                        state_next = ST_ERR1;
                    end else if (HAS_WAIT) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_INIT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_next    = ST_DONE;
                    wait_cnt_next = 4'd0;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                state_next = ST_ERR2;
            end
            default: begin
                state_next    = ST_IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase

        case (state_next)
            ST_WAIT: begin
                ready_next = 1'b0;
                resp_next  = RESP_OKAY;
            end
            ST_ERR1: begin
                ready_next = 1'b0;
                resp_next  = RESP_ERROR;
            end
            ST_ERR2: begin
                ready_next = 1'b1;
                resp_next  = RESP_ERROR;
            end
            default: begin
                ready_next = 1'b1;
                resp_next  = RESP_OKAY;
            end
        endcase
    end

    // FSM state, counter, registered handshake outputs and captured address phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            ready_r  <= 1'b1;
            resp_r   <= RESP_OKAY;
            idx_q    <= '0;
            wr_q     <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            ready_r  <= ready_next;
            resp_r   <= resp_next;
            if (accept) begin
                idx_q <= acc_idx;
                wr_q  <= bus.wr_req_in;
            end
        end
    end

    // RAM control: writes land at the end of DONE; reads are launched at accept
    // (no wait states) or in the last WAIT cycle so earlier writes are visible.
    logic          done_write;
    logic [3:0]    ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [31:0]   ram_rdata;
    logic          rd_at_accept;
    logic          rd_at_wait_end;
    logic          fwd_hit;

    assign done_write     = (state == ST_DONE) && wr_q && !rst;
    assign ram_we         = done_write ? bus.wr_mask_in : 4'b0000;
    assign rd_at_accept   = !HAS_WAIT && accept && !addr_oor && !bus.wr_req_in;
    assign rd_at_wait_end = (state == ST_WAIT) && (wait_cnt == 4'd1) && !wr_q;
    assign ram_re         = (rd_at_accept || rd_at_wait_end) && !rst;
    assign ram_raddr      = (state == ST_WAIT) ? idx_q : acc_idx;
    // The RAM returns pre-write data when a read is launched on the edge a
    // write to the same word lands, so the written lanes are captured here.
    assign fwd_hit        = rd_at_accept && done_write && (acc_idx == idx_q);

    msrv32_dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (bus.data_in),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Read-data qualifiers: forwarding lanes and the zero override for reset/ERR2.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_zero <= 1'b1;
            fwd_mask   <= 4'b0000;
            fwd_data   <= 32'h0000_0000;
        end else if (ram_re) begin
            rdata_zero <= 1'b0;
            fwd_mask   <= fwd_hit ? bus.wr_mask_in : 4'b0000;
            fwd_data   <= bus.data_in;
        end else if (state == ST_ERR1) begin
            rdata_zero <= 1'b1;
        end
    end

    assign bus.ahb_ready_out = ready_r;
    assign bus.ahb_resp_out  = resp_r;
    assign bus.rdata_out     = rdata_zero ? 32'h0000_0000
                                          : merge_lanes(fwd_mask, fwd_data, ram_rdata);

endmodule
